// File: rtl/dmem_arbiter_if.sv
// Purpose : bundles the CPU, external-master and DATA_MEM signal groups of the data-memory arbiter.
// Latency : wires only; read data on mem_rdata follows its access by one clk_core cycle.
// Backpr. : CPU is held off with cpu_stall, external master waits for ext_gnt; the BRAM never stalls.
//
// Modports:
//   slave  - the arbiter: it serves the requesters and drives the BRAM port.
//   master - the surroundings: CPU, external master and the BRAM itself.
// Signal groups:
//   cpu_*  request (req/we/addr/wdata), stall, read response (rvalid/rdata)
//   ext_*  request (req/we/addr/wdata), gnt, read response (rvalid/rdata)
//   mem_*  en/we/addr/wdata to the BRAM, rdata back with one cycle latency
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // CPU side (requester 0)
    logic              cpu_req;
    logic [BE_W-1:0]   cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // External master side (requester 1)
    logic              ext_req;
    logic [BE_W-1:0]   ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    // DATA_MEM block RAM port
    logic              mem_en;
    logic [BE_W-1:0]   mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose : shares the single-port DATA_MEM BRAM between the CPU (fixed priority) and an external master.
// Latency : access issued combinationally in its grant cycle; read response one cycle later.
// Backpr. : CPU held with cpu_stall, ext waits for ext_gnt; starvation counter forces an ext grant after MAX_WAIT denials.
//
// Ports:
//   clk_core       core clock
//   async_reset_n  asynchronous active-low reset
//   bus            dmem_arbiter_if.slave: cpu_*, ext_* requester groups and mem_* BRAM port
// Optional build macro ARB_PERF_CNT_EN adds:
//   perf_conflict_cnt  cycles with both requesters active while running
//   perf_force_cnt     cycles where a forced ext grant overrode a CPU request
// ADDR_W/DATA_W must match the parameters of the connected interface instance.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk_core,
    input  logic          async_reset_n,
    dmem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_conflict_cnt,
    output logic [31:0]   perf_force_cnt
`endif
);

    localparam int BE_W = DATA_W / 8;
    // MAX_WAIT is limited to 1..255, so an 8-bit counter always holds it.
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    // ------------------------------------------------------------------
    // Local views of the interface inputs
    // ------------------------------------------------------------------
    logic              cpu_req;
    logic [BE_W-1:0]   cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              ext_req;
    logic [BE_W-1:0]   ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign cpu_req   = bus.cpu_req;
    assign cpu_we    = bus.cpu_we;
    assign cpu_addr  = bus.cpu_addr;
    assign cpu_wdata = bus.cpu_wdata;
    assign ext_req   = bus.ext_req;
    assign ext_we    = bus.ext_we;
    assign ext_addr  = bus.ext_addr;
    assign ext_wdata = bus.ext_wdata;
    assign mem_rdata = bus.mem_rdata;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic       run;        // low for the first cycle after reset release
    logic [7:0] wait_cnt;   // consecutive cycles ext has been refused
    logic       rsp_valid;  // a read was issued last cycle
    logic       rsp_owner;  // 0 = CPU issued it, 1 = ext issued it

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic force_ext;
    logic grant_cpu;
    logic grant_ext;
    logic read_issue;

    assign force_ext = (wait_cnt == WAIT_LIMIT);
    // CPU wins every tie except when the starvation counter has run out
    // and ext is actually asking.
    assign grant_cpu = run & cpu_req & ~(force_ext & ext_req);
    assign grant_ext = run & ext_req & ~grant_cpu;

    assign read_issue = (grant_cpu & (cpu_we == '0)) |
                        (grant_ext & (ext_we == '0));

    // ------------------------------------------------------------------
    // BRAM port mux: the winner's request goes straight to the memory,
    // an idle port is driven to all-zero.
    // ------------------------------------------------------------------
    logic              mem_en;
    logic [BE_W-1:0]   mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_cpu) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (grant_ext) begin
            mem_en    = 1'b1;
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_core or negedge async_reset_n) begin
        if (!async_reset_n) begin
            run       <= 1'b0;
            wait_cnt  <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
        end else begin
            run <= 1'b1;

            // Starvation counter: counts refused ext cycles, saturates at
            // the limit so the force stays asserted until ext is served.
            if (grant_ext || !ext_req) begin
                wait_cnt <= 8'd0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            // The BRAM answers one cycle after the access; remember who
            // asked so the answer can be steered back. Writes never answer.
            rsp_valid <= read_issue;
            rsp_owner <= grant_ext;
        end
    end

    // ------------------------------------------------------------------
    // Handshake and response outputs
    // ------------------------------------------------------------------
    logic cpu_rvalid;
    logic ext_rvalid;

    assign cpu_rvalid = rsp_valid & ~rsp_owner;
    assign ext_rvalid = rsp_valid &  rsp_owner;

    // The stall term is gated by reset so that every output is quiet while
    // reset is held, even if the CPU is already asserting a request.
    assign bus.cpu_stall  = async_reset_n & cpu_req & ~grant_cpu;
    assign bus.ext_gnt    = grant_ext;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.ext_rvalid = ext_rvalid;
    // Read data is only meaningful alongside its rvalid; it is zeroed
    // otherwise so the response buses stay quiet in reset and when idle.
    assign bus.cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign bus.ext_rdata  = ext_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_core or negedge async_reset_n) begin
        if (!async_reset_n) begin
            perf_conflict_cnt <= 32'd0;
            perf_force_cnt    <= 32'd0;
        end else begin
            if (run && cpu_req && ext_req) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (force_ext && cpu_req && ext_req) begin
                perf_force_cnt <= perf_force_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : randomized and directed check of dmem_arbiter against a cycle-level reference model.
// Latency : checks grant/mux outputs in the request cycle and read responses one cycle later.
// Backpr. : stimulus holds a stalled CPU request and an ungranted ext request, as the protocol demands.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;

    logic clk_core = 1'b0;
    logic rst_n    = 1'b0;

    always #5 clk_core = ~clk_core;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflict_cnt;
    logic [31:0] perf_force_cnt;
`endif

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk_core      (clk_core),
        .async_reset_n (rst_n),
        .bus           (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_force_cnt    (perf_force_cnt)
`endif
    );

    // ------------------------------------------------------------------
    // BRAM model: 256 words, address bits [9:2], read data one cycle later
    // ------------------------------------------------------------------
    logic [31:0] bram [256];
    logic [31:0] bram_q;
    logic        bram_filled = 1'b0;

    always @(posedge clk_core) begin
        if (!bram_filled) begin
            for (int i = 0; i < 256; i++) bram[i] <= 32'hC0DE_0000 | 32'(i);
            bram_filled <= 1'b1;
        end else if (bus.mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) bram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bram_q <= bram[bus.mem_addr[9:2]];
        end
    end

    assign bus.mem_rdata = bram_q;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int          checks = 0;
    int          errors = 0;
    int          cyc_abs = 0;        // clock edges since time zero
    int          cyc_since_rst = 0;  // edges seen with reset released
    int          ext_since = 0;      // cycle in which the current ext wait began
    logic        pend_vld = 1'b0;    // read response due this cycle
    logic        pend_ext = 1'b0;
    logic [31:0] pend_data = '0;
    logic [31:0] ref_mem [256];
    logic        last_cpu_won = 1'b0;
    logic        last_ext_won = 1'b0;
    logic [31:0] m_conflict = '0;
    logic [31:0] m_forced = '0;

    // Observations from the most recent cycle, used by directed checks
    logic        obs_ext_gnt, obs_cpu_stall, obs_mem_en;
    logic        obs_cpu_rvalid, obs_ext_rvalid;
    logic [31:0] obs_ext_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_abs);
        end
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then let
    // the model absorb the edge.
    task automatic tick();
        logic        m_run, m_force, m_cw, m_ew;
        logic        c_req, e_req;
        logic [3:0]  c_we, e_we, x_we;
        logic [31:0] c_addr, e_addr, c_wd, e_wd, x_addr, x_wd;
        @(negedge clk_core);
        c_req = bus.cpu_req;  c_we = bus.cpu_we;  c_addr = bus.cpu_addr;  c_wd = bus.cpu_wdata;
        e_req = bus.ext_req;  e_we = bus.ext_we;  e_addr = bus.ext_addr;  e_wd = bus.ext_wdata;

        // Arbiter is live from the second edge after release; ext is forced
        // once it has been waiting MAX_WAIT cycles.
        m_run   = rst_n && (cyc_since_rst > 0);
        m_force = rst_n && ((cyc_abs - ext_since) >= MAX_WAIT);
        m_ew    = m_run && e_req && (m_force || !c_req);
        m_cw    = m_run && c_req && !m_ew;
        x_we    = m_cw ? c_we   : (m_ew ? e_we   : 4'h0);
        x_addr  = m_cw ? c_addr : (m_ew ? e_addr : 32'h0);
        x_wd    = m_cw ? c_wd   : (m_ew ? e_wd   : 32'h0);

        chk("mem_en",     bus.mem_en,     m_cw || m_ew);
        chk("mem_we",     bus.mem_we,     x_we);
        chk("mem_addr",   bus.mem_addr,   x_addr);
        chk("mem_wdata",  bus.mem_wdata,  x_wd);
        chk("cpu_stall",  bus.cpu_stall,  rst_n && c_req && !m_cw);
        chk("ext_gnt",    bus.ext_gnt,    m_ew);
        chk("cpu_rvalid", bus.cpu_rvalid, pend_vld && !pend_ext);
        chk("ext_rvalid", bus.ext_rvalid, pend_vld && pend_ext);
        chk("rvalid_excl", bus.cpu_rvalid && bus.ext_rvalid, 1'b0);
        if (pend_vld && !pend_ext) chk("cpu_rdata", bus.cpu_rdata, pend_data);
        if (pend_vld &&  pend_ext) chk("ext_rdata", bus.ext_rdata, pend_data);
`ifdef ARB_PERF_CNT_EN
        chk("perf_conflict", perf_conflict_cnt, m_conflict);
        chk("perf_force",    perf_force_cnt,    m_forced);
`endif
        obs_ext_gnt    = bus.ext_gnt;
        obs_cpu_stall  = bus.cpu_stall;
        obs_mem_en     = bus.mem_en;
        obs_cpu_rvalid = bus.cpu_rvalid;
        obs_ext_rvalid = bus.ext_rvalid;
        obs_ext_rdata  = bus.ext_rdata;

        @(posedge clk_core);
        if (!rst_n) begin
            cyc_since_rst = 0;
            pend_vld      = 1'b0;
            m_conflict    = '0;
            m_forced      = '0;
            ext_since     = cyc_abs + 1;
        end else begin
            if (m_run && c_req && e_req)   m_conflict = m_conflict + 32'd1;
            if (m_force && c_req && e_req) m_forced   = m_forced + 32'd1;
            pend_vld = (m_cw || m_ew) && (x_we == 4'h0);
            pend_ext = m_ew;
            if (m_cw || m_ew) begin
                pend_data = ref_mem[x_addr[9:2]];
                for (int b = 0; b < 4; b++) begin
                    if (x_we[b]) ref_mem[x_addr[9:2]][8*b +: 8] = x_wd[8*b +: 8];
                end
            end
            if (!e_req || m_ew) ext_since = cyc_abs + 1;
            cyc_since_rst++;
        end
        cyc_abs++;
        last_cpu_won = m_cw;
        last_ext_won = m_ew;
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        bus.cpu_req = req;  bus.cpu_we = we;  bus.cpu_addr = addr;  bus.cpu_wdata = wd;
    endtask

    task automatic set_ext(input logic req, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        bus.ext_req = req;  bus.ext_we = we;  bus.ext_addr = addr;  bus.ext_wdata = wd;
    endtask

    // Random next request; a refused request is held unchanged.
    task automatic rand_stim(input int p_cpu, input int p_ext);
        if (!(bus.cpu_req && !last_cpu_won)) begin
            set_cpu($urandom_range(0, 99) < p_cpu,
                    ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                    {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
        end
        if (!(bus.ext_req && !last_ext_won)) begin
            set_ext($urandom_range(0, 99) < p_ext,
                    ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                    {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
        end
    endtask

    task automatic assert_reset();
        rst_n         = 1'b0;
        pend_vld      = 1'b0;
        cyc_since_rst = 0;
        ext_since     = cyc_abs;
        m_conflict    = '0;
        m_forced      = '0;
    endtask

    initial begin
        int gnt_at;
`ifdef ARB_PERF_CNT_EN
        logic [31:0] pc0, pf0;
`endif
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_ext(1'b0, 4'h0, 32'h0, 32'h0);

        // Reset held with both requesters active: every output must be quiet.
        #1;
        set_cpu(1'b1, 4'h0, 32'h40, 32'h0);
        set_ext(1'b1, 4'h0, 32'h44, 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rel_c0_mem_en", obs_mem_en, 1'b0);
        tick();
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_ext(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) tick();

        // CPU-only read of 0x100, response next cycle
        set_cpu(1'b1, 4'h0, 32'h100, 32'h0);
        tick();
        chk("cpu_rd_stall", obs_cpu_stall, 1'b0);
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("cpu_rd_rvalid", obs_cpu_rvalid, 1'b1);

        // Ext-only partial write, then read back
        set_ext(1'b1, 4'b0011, 32'h20, 32'hA5A5_A5A5);
        tick();
        chk("ext_wr_gnt", obs_ext_gnt, 1'b1);
        set_ext(1'b1, 4'h0, 32'h20, 32'h0);
        tick();
        chk("ext_wr_no_rvalid", obs_ext_rvalid, 1'b0);
        set_ext(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("ext_rd_rvalid", obs_ext_rvalid, 1'b1);
        chk("ext_rd_lo", obs_ext_rdata[15:0], 16'hA5A5);

        // Response routing: CPU read then ext read on consecutive cycles
        set_cpu(1'b1, 4'h0, 32'h8, 32'h0);
        tick();
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_ext(1'b1, 4'h0, 32'hC, 32'h0);
        tick();
        chk("route_cpu_rv", obs_cpu_rvalid, 1'b1);
        chk("route_ext_rv_early", obs_ext_rvalid, 1'b0);
        set_ext(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("route_ext_rv", obs_ext_rvalid, 1'b1);
        chk("route_cpu_rv_late", obs_cpu_rvalid, 1'b0);

        // Contention: CPU requests every cycle, ext raised at cycle 0
        tick();
`ifdef ARB_PERF_CNT_EN
        pc0 = perf_conflict_cnt;
        pf0 = perf_force_cnt;
`endif
        set_cpu(1'b1, 4'h0, 32'h30, 32'h0);
        set_ext(1'b1, 4'h0, 32'h34, 32'h0);
        gnt_at = -1;
        for (int c = 0; c < 20 && gnt_at < 0; c++) begin
            tick();
            if (obs_ext_gnt) begin
                gnt_at = c;
                chk("cont_force_stall", obs_cpu_stall, 1'b1);
            end
        end
        chk("cont_gnt_cycle", 32'(gnt_at), 32'(MAX_WAIT));
`ifdef ARB_PERF_CNT_EN
        chk("cont_perf_conflict", perf_conflict_cnt - pc0, 32'd9);
        chk("cont_perf_force",    perf_force_cnt - pf0,    32'd1);
`endif
        set_ext(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("cont_c9_stall", obs_cpu_stall, 1'b0);
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Reset right after a granted read: its response must be dropped
        set_cpu(1'b1, 4'h0, 32'h50, 32'h0);
        tick();
        assert_reset();
        set_ext(1'b1, 4'h0, 32'h54, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_no_rvalid", obs_cpu_rvalid, 1'b0);
        chk("rst_c0_mem_en", obs_mem_en, 1'b0);
        tick();
        chk("rst_c1_mem_en", obs_mem_en, 1'b1);
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_ext(1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Randomized traffic in three contention regimes
        for (int n = 0; n < 3000; n++) begin
            if (n < 1000)      rand_stim(90, 60);
            else if (n < 2000) rand_stim(50, 50);
            else               rand_stim(20, 80);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port DATA_MEM block RAM between the processor core (requester 0) and an external bus master such as a debug loader or DMA (requester 1).
- Sits between processor_core, the external master and DATA_MEM, in the clk_core domain.
- CPU has fixed priority; a starvation counter forces an external grant after MAX_WAIT denied cycles.
- Tracks the BRAM's 1-cycle read latency and routes each read response to the requester that issued it.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width; byte-enable width is DATA_W/8
MAX_WAIT, 8, consecutive denied ext cycles before a forced ext grant (1..255)

Ports:
clk_core  in  1  core clock
async_reset_n  in  1  reset, asynchronous, active-low
cpu_req  in  1  CPU access request, valid this cycle
cpu_we  in  DATA_W/8  CPU byte write enables; all-zero = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_stall  out  1  CPU request not accepted this cycle; CPU holds its request
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
ext_req  in  1  ext request; held stable until ext_gnt
ext_we  in  DATA_W/8  ext byte write enables
ext_addr  in  ADDR_W  ext address
ext_wdata  in  DATA_W  ext write data
ext_gnt  out  1  ext request accepted this cycle
ext_rvalid  out  1  ext read data valid
ext_rdata  out  DATA_W  ext read data
mem_en  out  1  BRAM enable
mem_we  out  DATA_W/8  BRAM byte write enables
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data, 1-cycle latency

Behaviour:
- Reset (async_reset_n low):
  - wait_cnt = 0, rsp_valid = 0, rsp_owner = 0, run = 0.
  - All outputs 0, including cpu_stall and ext_gnt.
- run register: set to 1 on the first clk_core edge after reset release. While run = 0, no grants and mem_en = 0.
- Arbitration is combinational each cycle:
  - force = (wait_cnt == MAX_WAIT).
  - grant_cpu = run & cpu_req & ~(force & ext_req).
  - grant_ext = run & ext_req & ~grant_cpu.
- Memory mux:
  - grant_cpu: mem_* driven from cpu_*.
  - grant_ext: mem_* driven from ext_*.
  - In both cases mem_en = 1.
  - No grant: mem_en = 0, mem_we = 0, mem_addr and mem_wdata = 0.
- Handshake outputs:
  - cpu_stall = cpu_req & ~grant_cpu.
  - ext_gnt = grant_ext.
  - An access is issued exactly in its grant cycle; no buffering.
- wait_cnt (saturating at MAX_WAIT):
  - Cleared when grant_ext or ~ext_req.
  - Otherwise incremented when ext_req & ~grant_ext.
  - Within MAX_WAIT+1 cycles of ext_req rising, ext is guaranteed a grant.
- Response tracking (registered):
  - rsp_valid <= grant issued & (granted we == 0).
  - rsp_owner <= grant_ext.
  - Writes produce no rvalid.
- Response outputs:
  - cpu_rvalid = rsp_valid & ~rsp_owner; ext_rvalid = rsp_valid & rsp_owner.
  - cpu_rdata = ext_rdata = mem_rdata; data is meaningful only when the matching rvalid is high.
- Back-to-back: a new grant may issue in the same cycle a previous read's rvalid is asserted; full throughput is one access per cycle.
- Simultaneous requests: CPU wins unless force; under force ext wins and cpu_stall = 1 for that cycle.
- Reset mid-operation: a pending rsp_valid is dropped; no rvalid is asserted after reset release for pre-reset accesses.

Optional Feature:
ARB_PERF_CNT_EN
- Defined:
  - Adds outputs perf_conflict_cnt[31:0] and perf_force_cnt[31:0].
  - perf_conflict_cnt increments on cycles with run & cpu_req & ext_req.
  - perf_force_cnt increments on cycles where force & cpu_req & ext_req.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- CPU only: read 0x100 -> mem_en=1, mem_addr=0x100 in cycle N; cpu_rvalid=1 with cpu_rdata=mem_rdata in N+1; cpu_stall=0 throughout.
- Ext only: write we=4'b0011 to 0x20 with data 0xA5A5A5A5 -> ext_gnt=1 in the same cycle, mem_we=4'b0011, no ext_rvalid; a subsequent read of 0x20 returns lower halfword 0xA5A5.
- Contention, MAX_WAIT=8: cpu_req held high and ext_req raised at cycle 0 -> ext_gnt=0 for cycles 0-7; cycle 8 ext_gnt=1 and cpu_stall=1; cycle 9 CPU is granted again and wait_cnt=0.
- Read response routing: CPU read in cycle N, ext read in N+1 -> cpu_rvalid only in N+1, ext_rvalid only in N+2; never both at once.
- Reset: assert async_reset_n low the cycle after a granted read -> no rvalid after release; run=0 and mem_en=0 for the first cycle after release; grants resume the following cycle.
- With ARB_PERF_CNT_EN: contention scenario above -> perf_conflict_cnt=9, perf_force_cnt=1.
